ps2_key_decoder: RTL

Downstream stage of the PS/2 byte receiver in the keypad-calculator path. Consumes one validated scan byte per strobe and tracks make/break (F0) and extended (E0) prefixes. Maps keypad make codes to 4-bit key tokens and buffers them in a small FIFO. The calculator/CPU side drains the FIFO over a valid/ready handshake.

---
 rtl/ps2_key_pkg.sv | 72 +++++++
 rtl/ps2_key_decoder_fifo.sv | 90 +++++++++
 rtl/ps2_key_decoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ps2_key_pkg.sv
// ----------------------------------------------------------------------------
// ps2_key_pkg
//   Shared definitions for the PS/2 keypad decoder path:
//     - scan-code constants (E0 extended prefix, F0 break prefix, keypad codes)
//     - key_tok_t      : 4-bit key token delivered to the calculator side
//     - dec_state_t    : prefix-tracking FSM state
//     - key_map_t      : {hit, tok} result of a scan-byte lookup
//     - map_scan()     : scan byte -> {hit, token}
// ----------------------------------------------------------------------------
package ps2_key_pkg;

    localparam logic [7:0] SC_E0   = 8'hE0;
    localparam logic [7:0] SC_F0   = 8'hF0;

    localparam logic [7:0] SC_KP0  = 8'h70;
    localparam logic [7:0] SC_KP1  = 8'h69;
    localparam logic [7:0] SC_KP2  = 8'h72;
    localparam logic [7:0] SC_KP3  = 8'h7A;
    localparam logic [7:0] SC_KP4  = 8'h6B;
    localparam logic [7:0] SC_KP5  = 8'h73;
    localparam logic [7:0] SC_KP6  = 8'h74;
    localparam logic [7:0] SC_KP7  = 8'h6C;
    localparam logic [7:0] SC_KP8  = 8'h75;
    localparam logic [7:0] SC_KP9  = 8'h7D;
    localparam logic [7:0] SC_KP10 = 8'h79;
    localparam logic [7:0] SC_KP11 = 8'h7B;
    localparam logic [7:0] SC_KP12 = 8'h7C;
    localparam logic [7:0] SC_KP13 = 8'h4A;
    localparam logic [7:0] SC_KP14 = 8'h5A;
    localparam logic [7:0] SC_KP15 = 8'h76;

    typedef logic [3:0] key_tok_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic     hit;
        key_tok_t tok;
    } key_map_t;

    function automatic key_map_t map_scan(input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.tok = '0;
        case (code)
            SC_KP0:  m.tok = 4'd0;
            SC_KP1:  m.tok = 4'd1;
            SC_KP2:  m.tok = 4'd2;
            SC_KP3:  m.tok = 4'd3;
            SC_KP4:  m.tok = 4'd4;
            SC_KP5:  m.tok = 4'd5;
            SC_KP6:  m.tok = 4'd6;
            SC_KP7:  m.tok = 4'd7;
            SC_KP8:  m.tok = 4'd8;
            SC_KP9:  m.tok = 4'd9;
            SC_KP10: m.tok = 4'd10;
            SC_KP11: m.tok = 4'd11;
            SC_KP12: m.tok = 4'd12;
            SC_KP13: m.tok = 4'd13;
            SC_KP14: m.tok = 4'd14;
            SC_KP15: m.tok = 4'd15;
            default: m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_fifo.sv
// ----------------------------------------------------------------------------
// key_fifo
//   First-word-fall-through token FIFO with occupancy count and sticky
//   overflow flag. Occupancy is a separate counter (0..DEPTH); pointers wrap
//   modulo DEPTH.
//   Parameters:
//     DEPTH        entries, power of two, 2..16
//   Ports:
//     clk_i        system clock
//     rst_ni       asynchronous active-low reset
//     push_i       write push_data_i (dropped if full without a same-cycle pop)
//     push_data_i  token to write
//     pop_i        consumer ready; a pop happens only while valid_o=1
//     valid_o      FIFO non-empty
//     data_o       head entry (stale value when empty)
//     count_o      current occupancy
//     overflow_o   sticky: a push was dropped on full
// ----------------------------------------------------------------------------
module key_fifo
    import ps2_key_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  key_tok_t                 push_data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output key_tok_t                 data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    key_tok_t       mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           ovf_q;

    logic           full;
    logic           do_pop;
    logic           do_push;
    logic           drop;

    always_comb begin
        full    = (count_q == FULL_CNT);
        do_pop  = pop_i && (count_q != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_push = push_i && (!full || do_pop);
        drop    = push_i && full && !do_pop;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign valid_o    = (count_q != '0);
    assign data_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder
//   Consumes validated PS/2 scan bytes, tracks E0/F0 prefixes, maps keypad
//   make codes to 4-bit tokens and buffers them in key_fifo for the
//   calculator side (valid/ready drain).
//   Optional feature macro: KEY_REPEAT_FILTER_EN
//     defined   -> typematic repeats of the held key are suppressed until its
//                  break code (or a scan error) is seen
//     undefined -> every make pushes a token
//   Parameters:
//     DEPTH       FIFO entries, power of two, 2..16
//   Ports:
//     CLK         system clock
//     RST_N       asynchronous active-low reset
//     SCAN_VALID  one-cycle strobe qualifying SCAN_CODE/SCAN_ERR
//     SCAN_CODE   received scan byte
//     SCAN_ERR    parity/framing error on this byte
//     KEY_VALID   FIFO non-empty
//     KEY_CODE    head token (first-word-fall-through)
//     KEY_READY   consumer accepts head when KEY_VALID=1
//     KEY_COUNT   FIFO occupancy
//     OVERFLOW    sticky: a token was dropped on full
// ----------------------------------------------------------------------------
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     SCAN_VALID,
    input  logic [7:0]               SCAN_CODE,
    input  logic                     SCAN_ERR,
    output logic                     KEY_VALID,
    output logic [3:0]               KEY_CODE,
    input  logic                     KEY_READY,
    output logic [$clog2(DEPTH):0]   KEY_COUNT,
    output logic                     OVERFLOW
);

    dec_state_t state_q;
    logic       push_q;
    key_tok_t   tok_q;

    key_map_t   map;
    logic       ext_hit;
    logic       good_byte;
    logic       make_en;
    logic       brk_match;
    logic       suppress;

`ifdef KEY_REPEAT_FILTER_EN
    key_tok_t   hold_tok_q;
    logic       hold_vld_q;
`endif

    always_comb begin
        map       = map_scan(SCAN_CODE);
        // Only the keypad '/' and Enter are meaningful after E0; arrows and
        // other extended keys share codes with digits and must not map.
        ext_hit   = (SCAN_CODE == SC_KP13) || (SCAN_CODE == SC_KP14);
        good_byte = SCAN_VALID && !SCAN_ERR;
        make_en   = good_byte &&
                    (((state_q == ST_IDLE) && map.hit) ||
                     ((state_q == ST_EXT)  && ext_hit));
        brk_match = good_byte &&
                    (((state_q == ST_BRK)     && map.hit) ||
                     ((state_q == ST_EXT_BRK) && ext_hit));
`ifdef KEY_REPEAT_FILTER_EN
        suppress  = hold_vld_q && (map.tok == hold_tok_q);
`else
        suppress  = 1'b0;
`endif
    end

    // Decode stage: the push request and token are registered here and the
    // FIFO writes them on the following edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            push_q     <= 1'b0;
            tok_q      <= '0;
`ifdef KEY_REPEAT_FILTER_EN
            hold_tok_q <= '0;
            hold_vld_q <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;

            if (SCAN_VALID) begin
                if (SCAN_ERR) begin
                    state_q <= ST_IDLE;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (SCAN_CODE == SC_E0)      state_q <= ST_EXT;
                            else if (SCAN_CODE == SC_F0) state_q <= ST_BRK;
                            else                         state_q <= ST_IDLE;
                        end
                        ST_EXT: begin
                            if (SCAN_CODE == SC_F0) state_q <= ST_EXT_BRK;
                            else                    state_q <= ST_IDLE;
                        end
                        ST_BRK:     state_q <= ST_IDLE;
                        ST_EXT_BRK: state_q <= ST_IDLE;
                        default:    state_q <= ST_IDLE;
                    endcase
                end
            end

            if (make_en && !suppress) begin
                push_q <= 1'b1;
                tok_q  <= map.tok;
            end

`ifdef KEY_REPEAT_FILTER_EN
            if (SCAN_VALID && SCAN_ERR) begin
                hold_vld_q <= 1'b0;
            end else if (make_en && !suppress) begin
                hold_tok_q <= map.tok;
                hold_vld_q <= 1'b1;
            end else if (brk_match && (map.tok == hold_tok_q)) begin
                hold_vld_q <= 1'b0;
            end
`else
            if (brk_match) begin
                // Break codes never push; nothing to track without the filter.
            end
`endif
        end
    end

    key_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .push_i      (push_q),
        .push_data_i (tok_q),
        .pop_i       (KEY_READY),
        .valid_o     (KEY_VALID),
        .data_o      (KEY_CODE),
        .count_o     (KEY_COUNT),
        .overflow_o  (OVERFLOW)
    );

endmodule
